// File: rtl/game_pkg.sv
// Shared types and constants for the sudoku game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADING = 3'd1,
    ST_PLAYING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_VICTORY = 3'd4,
    ST_DEFEAT  = 3'd5
  } state_t;

  localparam logic       EASY       = 1'b0;
  localparam logic       HARD       = 1'b1;
  localparam logic [1:0] STRIKE_MAX = 2'b11;

  // Strike count plus one, holding at STRIKE_MAX.
  function automatic logic [1:0] strike_inc(input logic [1:0] s);
    return (s == STRIKE_MAX) ? s : s + 2'd1;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_FREQ-1 while enabled, pulses tick on wrap.
module sec_tick_gen #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] r_cnt;

  // Tick is combinational so the timer advances on the same edge the prescaler wraps.
  assign tick = en && (r_cnt == LAST);

  // Prescaler: clear has priority, holds when not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: FSM plus elapsed-time, strike and difficulty registers.
module game_ctrl
  import game_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TIMER_W  = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic               difficulty_sel,
  input  logic               wrong_move,
  input  logic               board_ready,
  input  logic               victory_condition,
  input  logic               defeat_condition,
  output logic               load_board,
  output logic [2:0]         state,
  output logic [TIMER_W-1:0] timer,
  output logic [1:0]         strikes,
  output logic               difficulty,
  output logic               game_over
);

  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  state_t             r_state;
  state_t             w_state_next;
  logic [TIMER_W-1:0] r_timer,  w_timer_next;
  logic [1:0]         r_strikes, w_strikes_next;
  logic               r_difficulty, w_difficulty_next;
  logic               r_load_board, w_load_board_next;
  logic               r_game_over, w_game_over_next;
  logic               w_end;
  logic               w_live;
  logic               w_tick;
  logic               w_tick_clr;

  // Counters only advance in a PLAYING cycle that is not ending the game,
  // so the frozen end-screen values are the ones that caused the end.
  assign w_end      = victory_condition || defeat_condition;
  assign w_live     = (r_state == ST_PLAYING) && !w_end;
  assign w_tick_clr = (r_state == ST_IDLE) || (r_state == ST_LOADING);

  sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (w_live),
    .clr  (w_tick_clr),
    .tick (w_tick)
  );

  // Next-state and next-register computation.
  always_comb begin
    w_state_next      = r_state;
    w_timer_next      = r_timer;
    w_strikes_next    = r_strikes;
    w_difficulty_next = r_difficulty;
    w_load_board_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next      = ST_LOADING;
          w_difficulty_next = difficulty_sel;
          w_load_board_next = 1'b1;
        end
      end
      ST_LOADING: if (board_ready) w_state_next = ST_PLAYING;
      ST_PLAYING: begin
        if (victory_condition)     w_state_next = ST_VICTORY;
        else if (defeat_condition) w_state_next = ST_DEFEAT;
        else if (pause)            w_state_next = ST_PAUSED;
      end
      ST_PAUSED:  if (pause) w_state_next = ST_PLAYING;
      ST_VICTORY, ST_DEFEAT: if (start) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase

    if (w_state_next == ST_IDLE) begin
      w_timer_next   = '0;
      w_strikes_next = '0;
    end else if (w_live) begin
      if (w_tick && (r_timer != TIMER_MAX)) w_timer_next = r_timer + TIMER_W'(1);
      if (wrong_move) w_strikes_next = strike_inc(r_strikes);
    end

    w_game_over_next = (w_state_next == ST_VICTORY) || (w_state_next == ST_DEFEAT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_strikes    <= '0;
      r_difficulty <= EASY;
      r_load_board <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_strikes    <= w_strikes_next;
      r_difficulty <= w_difficulty_next;
      r_load_board <= w_load_board_next;
      r_game_over  <= w_game_over_next;
    end
  end

  assign state      = r_state;
  assign timer      = r_timer;
  assign strikes    = r_strikes;
  assign difficulty = r_difficulty;
  assign load_board = r_load_board;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed vector bench for game_ctrl.
module tb_game_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: fast timer.
  logic        start = 0, pause = 0, dsel = 0, wm = 0, br = 0, vic = 0, def = 0;
  logic        load_board, difficulty, game_over;
  logic [2:0]  state;
  logic [10:0] timer;
  logic [1:0]  strikes;

  game_ctrl #(.CLK_FREQ(4), .TIMER_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .difficulty_sel(dsel), .wrong_move(wm), .board_ready(br),
    .victory_condition(vic), .defeat_condition(def),
    .load_board(load_board), .state(state), .timer(timer),
    .strikes(strikes), .difficulty(difficulty), .game_over(game_over)
  );

  // Saturation instance: 3-bit timer, 2-cycle second.
  logic        s_start = 0, s_br = 0;
  logic        s_load, s_diff, s_go;
  logic [2:0]  s_state;
  logic [2:0]  s_timer;
  logic [1:0]  s_strikes;

  game_ctrl #(.CLK_FREQ(2), .TIMER_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .pause(1'b0),
    .difficulty_sel(1'b0), .wrong_move(1'b0), .board_ready(s_br),
    .victory_condition(1'b0), .defeat_condition(1'b0),
    .load_board(s_load), .state(s_state), .timer(s_timer),
    .strikes(s_strikes), .difficulty(s_diff), .game_over(s_go)
  );

  typedef struct {
    int         n;
    logic       st, pa, ds, wm, br, vi, de;
    logic [2:0] e_state;
    int         e_timer;
    logic [1:0] e_str;
    logic       e_diff, e_load, e_go;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end else begin
      $display("ok   %s: %h", nm, got);
    end
  endtask

  function automatic logic [31:0] pack_main();
    return {13'd0, state, timer, strikes, difficulty, load_board, game_over};
  endfunction

  function automatic logic [31:0] pack_exp(input logic [2:0] s, input int t, input logic [1:0] k,
                                           input logic d, input logic l, input logic g);
    return {13'd0, s, t[10:0], k, d, l, g};
  endfunction

  task automatic drive(input logic a_st, a_pa, a_ds, a_wm, a_br, a_vi, a_de);
    start = a_st; pause = a_pa; dsel = a_ds; wm = a_wm; br = a_br; vic = a_vi; def = a_de;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    //                 n  st pa ds wm br vi de  state t  str d  ld go
    vecs.push_back('{ 1, 1, 0, 1, 0, 0, 0, 0, 3'd1, 0, 2'd0, 1, 1, 0});
    vecs.push_back('{ 1, 1, 1, 0, 1, 0, 0, 0, 3'd1, 0, 2'd0, 1, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 0, 1, 0, 0, 3'd2, 0, 2'd0, 1, 0, 0});
    vecs.push_back('{12, 0, 0, 0, 0, 0, 0, 0, 3'd2, 3, 2'd0, 1, 0, 0});
    vecs.push_back('{ 2, 0, 0, 0, 0, 0, 0, 0, 3'd2, 3, 2'd0, 1, 0, 0});
    vecs.push_back('{ 1, 0, 1, 0, 0, 0, 0, 0, 3'd3, 3, 2'd0, 1, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 1, 0, 0, 0, 3'd3, 3, 2'd0, 1, 0, 0});
    vecs.push_back('{10, 0, 0, 0, 0, 0, 0, 0, 3'd3, 3, 2'd0, 1, 0, 0});
    vecs.push_back('{ 1, 1, 0, 0, 0, 0, 1, 1, 3'd3, 3, 2'd0, 1, 0, 0});
    vecs.push_back('{ 1, 0, 1, 0, 0, 0, 0, 0, 3'd2, 3, 2'd0, 1, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 0, 0, 0, 0, 3'd2, 4, 2'd0, 1, 0, 0});
    vecs.push_back('{ 3, 0, 0, 0, 0, 0, 0, 0, 3'd2, 4, 2'd0, 1, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 1, 0, 0, 0, 3'd2, 5, 2'd1, 1, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 1, 0, 0, 0, 3'd2, 5, 2'd2, 1, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 1, 0, 0, 0, 3'd2, 5, 2'd3, 1, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 1, 0, 0, 0, 3'd2, 5, 2'd3, 1, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 1, 0, 0, 0, 3'd2, 6, 2'd3, 1, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 0, 0, 1, 0, 3'd4, 6, 2'd3, 1, 0, 1});
    vecs.push_back('{20, 0, 1, 0, 1, 0, 0, 0, 3'd4, 6, 2'd3, 1, 0, 1});
    vecs.push_back('{ 1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 1, 0, 0});
    vecs.push_back('{ 1, 1, 0, 0, 0, 0, 0, 0, 3'd1, 0, 2'd0, 0, 1, 0});
    vecs.push_back('{ 1, 0, 0, 0, 0, 1, 0, 0, 3'd2, 0, 2'd0, 0, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 0, 0, 1, 1, 3'd4, 0, 2'd0, 0, 0, 1});
    vecs.push_back('{ 1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0});
    vecs.push_back('{ 1, 1, 0, 1, 0, 0, 0, 0, 3'd1, 0, 2'd0, 1, 1, 0});
    vecs.push_back('{ 1, 0, 0, 0, 0, 1, 0, 0, 3'd2, 0, 2'd0, 1, 0, 0});
    vecs.push_back('{ 5, 0, 0, 0, 0, 0, 0, 0, 3'd2, 1, 2'd0, 1, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 1, 0, 0, 0, 3'd2, 1, 2'd1, 1, 0, 0});
    vecs.push_back('{ 1, 0, 1, 0, 1, 0, 0, 0, 3'd3, 1, 2'd2, 1, 0, 0});
    vecs.push_back('{ 1, 0, 1, 0, 0, 0, 0, 0, 3'd2, 1, 2'd2, 1, 0, 0});
    vecs.push_back('{ 1, 0, 0, 0, 0, 0, 0, 1, 3'd5, 1, 2'd2, 1, 0, 1});
    vecs.push_back('{ 5, 0, 1, 0, 1, 0, 0, 0, 3'd5, 1, 2'd2, 1, 0, 1});
    vecs.push_back('{ 1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 1, 0, 0});
    vecs.push_back('{ 3, 0, 1, 0, 1, 0, 0, 0, 3'd0, 0, 2'd0, 1, 0, 0});

    // Reset state.
    #12;
    chk("reset_main", pack_main(), pack_exp(3'd0, 0, 2'd0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].pa, vecs[i].ds, vecs[i].wm, vecs[i].br, vecs[i].vi, vecs[i].de);
      cyc(vecs[i].n);
      chk($sformatf("vec%0d", i), pack_main(),
          pack_exp(vecs[i].e_state, vecs[i].e_timer, vecs[i].e_str,
                   vecs[i].e_diff, vecs[i].e_load, vecs[i].e_go));
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-game with timer=7, strikes=2.
    drive(1, 0, 1, 0, 0, 0, 0); cyc(1);
    drive(0, 0, 0, 0, 1, 0, 0); cyc(1);
    drive(0, 0, 0, 0, 0, 0, 0); cyc(28);
    drive(0, 0, 0, 1, 0, 0, 0); cyc(2);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset", pack_main(), pack_exp(3'd2, 7, 2'd2, 1, 0, 0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset", pack_main(), pack_exp(3'd0, 0, 2'd0, 0, 0, 0));
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 1, 0, 0, 0, 0); cyc(1);
    chk("restart_load", pack_main(), pack_exp(3'd1, 0, 2'd0, 1, 1, 0));
    drive(0, 0, 0, 0, 0, 0, 0); cyc(1);
    chk("load_one_cycle", pack_main(), pack_exp(3'd1, 0, 2'd0, 1, 0, 0));

    // Timer saturation on the 3-bit instance.
    s_start = 1; cyc(1);
    s_start = 0; s_br = 1; cyc(1);
    s_br = 0;
    chk("sat_playing", {29'd0, s_state}, 32'd2);
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      chk($sformatf("sat_t%0d", k), {29'd0, s_timer}, (k / 2 > 7) ? 32'd7 : 32'(k / 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
